// File: rtl/dual_issue_ctrl.sv
// rtl/dual_issue_ctrl.sv - dual-fetch issue sequencer: fetch PC, IF/ID hold/flush, slot issue enables
// Optional statistics counters: define DUAL_ISSUE_STATS_EN.
module dual_issue_ctrl #(
   parameter int          PC_W    = 4,
   parameter logic [5:0]  OP_LW   = 6'h23,
   parameter logic [5:0]  OP_SW   = 6'h2B,
   parameter logic [5:0]  OP_ADDI = 6'h08
) (
   input  logic            reloj,
   input  logic            resetIF,
   input  logic            pair_valid,
   input  logic [5:0]      opcode1,
   input  logic [5:0]      opcode2,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rt1,
   input  logic [4:0]      rd1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rt2,
   input  logic [4:0]      rd2,
   input  logic            ex_load,
   input  logic [4:0]      ex_rt,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_4,
   output logic [PC_W-1:0] pc_8,
   output logic            ifid_hold,
   output logic            ifid_flush,
   output logic            issue1,
   output logic            issue2,
   output logic [1:0]      state,
   output logic [15:0]     dual_cnt,
   output logic [15:0]     split_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SPLIT = 2'd1,
      STALL = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
   localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

   state_t          state_q, state_next;
   logic [PC_W-1:0] pc_q, pc_next;

   logic            dest1_valid;
   logic [4:0]      dest1;
   logic            dep, memconf, lu1, lu2;
   logic            mem1, mem2;

   // rd2 is part of the IF/ID bundle but slot 2 never produces a hazard by its destination
   logic            unused_fields;
   assign unused_fields = ^rd2;

   // true when register r is one of the sources read by an instruction
   function automatic logic reads_reg(input logic [4:0] r, input logic [5:0] op,
                                      input logic [4:0] rs, input logic [4:0] rt);
      logic hit;
      hit = (r == rs);
      if ((op == 6'h00) || (op == OP_SW))
         hit = hit || (r == rt);
      return hit;
   endfunction

   // slot-1 destination, register 0 never counts as a write
   always_comb begin
      dest1       = 5'd0;
      dest1_valid = 1'b0;
      if (opcode1 == 6'h00) begin
         dest1       = rd1;
         dest1_valid = (rd1 != 5'd0);
      end else if ((opcode1 == OP_LW) || (opcode1 == OP_ADDI)) begin
         dest1       = rt1;
         dest1_valid = (rt1 != 5'd0);
      end
   end

   assign mem1    = (opcode1 == OP_LW) || (opcode1 == OP_SW);
   assign mem2    = (opcode2 == OP_LW) || (opcode2 == OP_SW);
   assign dep     = dest1_valid && reads_reg(dest1, opcode2, rs2, rt2);
   assign memconf = mem1 && mem2;
   assign lu1     = ex_load && (ex_rt != 5'd0) && reads_reg(ex_rt, opcode1, rs1, rt1);
   assign lu2     = ex_load && (ex_rt != 5'd0) && reads_reg(ex_rt, opcode2, rs2, rt2);

   // next-state, next-pc and issue/hold/flush decisions; a taken branch overrides everything
   always_comb begin
      state_next = state_q;
      pc_next    = pc_q;
      issue1     = 1'b0;
      issue2     = 1'b0;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      if (br_taken) begin
         ifid_flush = 1'b1;
         pc_next    = br_target;
         state_next = FLUSH;
      end else begin
         case (state_q)
            RUN: begin
               if (!pair_valid) begin
                  pc_next = pc_q + PC_TWO;
               end else if (lu1 || lu2) begin
                  ifid_hold  = 1'b1;
                  state_next = STALL;
               end else if (dep || memconf) begin
                  issue1     = 1'b1;
                  ifid_hold  = 1'b1;
                  state_next = SPLIT;
               end else begin
                  issue1  = 1'b1;
                  issue2  = 1'b1;
                  pc_next = pc_q + PC_TWO;
               end
            end
            SPLIT: begin
               if (lu2) begin
                  ifid_hold = 1'b1;
               end else begin
                  issue2     = 1'b1;
                  pc_next    = pc_q + PC_TWO;
                  state_next = RUN;
               end
            end
            STALL: begin
               ifid_hold  = 1'b1;
               state_next = RUN;
            end
            default: begin
               // FLUSH: the pair in IF/ID was fetched before the redirect and is stale
               pc_next    = pc_q + PC_TWO;
               state_next = RUN;
            end
         endcase
      end
   end

   // pc and state registers
   always_ff @(posedge reloj) begin
      if (!resetIF) begin
         pc_q    <= '0;
         state_q <= RUN;
      end else begin
         pc_q    <= pc_next;
         state_q <= state_next;
      end
   end

   assign pc    = pc_q;
   assign pc_4  = pc_q + PC_ONE;
   assign pc_8  = pc_q + PC_TWO;
   assign state = state_q;

`ifdef DUAL_ISSUE_STATS_EN
   logic [15:0] dual_q, split_q;

   // saturating counts of dual-issue cycles and entries into SPLIT
   always_ff @(posedge reloj) begin
      if (!resetIF) begin
         dual_q  <= '0;
         split_q <= '0;
      end else begin
         if (issue1 && issue2 && (dual_q != 16'hFFFF))
            dual_q <= dual_q + 16'd1;
         if ((state_q != SPLIT) && (state_next == SPLIT) && (split_q != 16'hFFFF))
            split_q <= split_q + 16'd1;
      end
   end

   assign dual_cnt  = dual_q;
   assign split_cnt = split_q;
`else
   assign dual_cnt  = 16'd0;
   assign split_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb/tb_dual_issue_ctrl.sv - table-driven bench for dual_issue_ctrl
module tb_dual_issue_ctrl;

   logic        reloj = 1'b0;
   logic        resetIF;
   logic        pair_valid;
   logic [5:0]  opcode1, opcode2;
   logic [4:0]  rs1, rt1, rd1, rs2, rt2, rd2;
   logic        ex_load;
   logic [4:0]  ex_rt;
   logic        br_taken;
   logic [3:0]  br_target;
   logic [3:0]  pc, pc_4, pc_8;
   logic        ifid_hold, ifid_flush, issue1, issue2;
   logic [1:0]  state;
   logic [15:0] dual_cnt, split_cnt;

   always #5 reloj = ~reloj;

   dual_issue_ctrl dut (
      .reloj(reloj), .resetIF(resetIF), .pair_valid(pair_valid),
      .opcode1(opcode1), .opcode2(opcode2),
      .rs1(rs1), .rt1(rt1), .rd1(rd1), .rs2(rs2), .rt2(rt2), .rd2(rd2),
      .ex_load(ex_load), .ex_rt(ex_rt), .br_taken(br_taken), .br_target(br_target),
      .pc(pc), .pc_4(pc_4), .pc_8(pc_8),
      .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
      .issue1(issue1), .issue2(issue2), .state(state),
      .dual_cnt(dual_cnt), .split_cnt(split_cnt)
   );

   localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, AI = 6'h08;
   localparam logic [1:0] S_RUN = 2'd0, S_SPLIT = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;

   typedef struct {
      logic       rst_n;
      logic       pv;
      logic [5:0] op1, op2;
      logic [4:0] rs1, rt1, rd1, rs2, rt2;
      logic       exl;
      logic [4:0] ex_rt;
      logic       br;
      logic [3:0] tgt;
      logic [3:0] e_pc;
      logic [1:0] e_st;
      logic [3:0] e_out;   // {issue1, issue2, hold, flush}
   } vec_t;

   vec_t        vecs[$];
   int          checks = 0;
   int          failures = 0;
   int          row = 0;
   logic [15:0] exp_dual = 16'd0;
   logic [15:0] exp_split = 16'd0;
   logic [3:0]  exp_pc;

   task automatic add_vec(input logic rst_n, input logic pv, input logic [5:0] op1, input logic [5:0] op2,
                          input logic [4:0] a1, input logic [4:0] b1, input logic [4:0] d1,
                          input logic [4:0] a2, input logic [4:0] b2,
                          input logic exl, input logic [4:0] ert, input logic br, input logic [3:0] tgt,
                          input logic [3:0] e_pc, input logic [1:0] e_st, input logic [3:0] e_out);
      vec_t v;
      v.rst_n = rst_n; v.pv = pv; v.op1 = op1; v.op2 = op2;
      v.rs1 = a1; v.rt1 = b1; v.rd1 = d1; v.rs2 = a2; v.rt2 = b2;
      v.exl = exl; v.ex_rt = ert; v.br = br; v.tgt = tgt;
      v.e_pc = e_pc; v.e_st = e_st; v.e_out = e_out;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      resetIF = v.rst_n; pair_valid = v.pv; opcode1 = v.op1; opcode2 = v.op2;
      rs1 = v.rs1; rt1 = v.rt1; rd1 = v.rd1; rs2 = v.rs2; rt2 = v.rt2; rd2 = 5'd0;
      ex_load = v.exl; ex_rt = v.ex_rt; br_taken = v.br; br_target = v.tgt;
   endtask

   task automatic check_counters();
      check("dual_cnt", dual_cnt, exp_dual);
      check("split_cnt", split_cnt, exp_split);
   endtask

   task automatic advance_model(input logic rst_n, input logic [1:0] st, input logic i1, input logic i2);
      if (!rst_n) begin
         exp_dual  = 16'd0;
         exp_split = 16'd0;
      end else begin
`ifdef DUAL_ISSUE_STATS_EN
         if (i1 && i2) exp_dual = exp_dual + 16'd1;
         if ((st == S_RUN) && i1 && !i2) exp_split = exp_split + 16'd1;
`else
         if (st == 2'bxx || i1 === 1'bx || i2 === 1'bx) exp_dual = exp_dual;
`endif
      end
   endtask

   initial begin
      vec_t v;
      // rst pv op1 op2 rs1 rt1 rd1 rs2 rt2 exl ert br tgt | pc st {i1,i2,hold,flush}
      add_vec(0, 0, R,  R,  0, 0, 0, 0, 0,  0, 0,  0, 0,   0, S_RUN,   4'b0000);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,   0, S_RUN,   4'b1100);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,   2, S_RUN,   4'b1100);
      add_vec(1, 1, R,  R,  1, 2, 7, 7, 5,  0, 0,  0, 0,   4, S_RUN,   4'b1010);
      add_vec(1, 1, R,  R,  1, 2, 7, 7, 5,  0, 0,  0, 0,   4, S_SPLIT, 4'b0100);
      add_vec(1, 1, LW, SW, 1, 10,0, 2, 3,  0, 0,  0, 0,   6, S_RUN,   4'b1010);
      add_vec(1, 1, LW, SW, 1, 10,0, 2, 3,  0, 0,  0, 0,   6, S_SPLIT, 4'b0100);
      add_vec(1, 1, R,  R,  9, 1, 3, 4, 5,  1, 9,  0, 0,   8, S_RUN,   4'b0010);
      add_vec(1, 1, R,  R,  9, 1, 3, 4, 5,  0, 0,  0, 0,   8, S_STALL, 4'b0010);
      add_vec(1, 1, R,  R,  9, 1, 3, 4, 5,  0, 0,  0, 0,   8, S_RUN,   4'b1100);
      add_vec(1, 1, R,  R,  1, 2, 7, 7, 5,  0, 0,  0, 0,  10, S_RUN,   4'b1010);
      add_vec(1, 1, R,  R,  1, 2, 7, 7, 5,  0, 0,  1, 11, 10, S_SPLIT, 4'b0001);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,  11, S_FLUSH, 4'b0000);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,  13, S_RUN,   4'b1100);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,  15, S_RUN,   4'b1100);
      add_vec(1, 0, R,  R,  1, 2, 3, 4, 5,  0, 0,  0, 0,   1, S_RUN,   4'b0000);
      add_vec(1, 1, R,  R,  1, 2, 3, 4, 9,  1, 9,  0, 0,   3, S_RUN,   4'b0010);
      add_vec(0, 1, R,  R,  1, 2, 3, 4, 9,  0, 0,  0, 0,   3, S_STALL, 4'b0010);
      add_vec(1, 0, R,  R,  0, 0, 0, 0, 0,  0, 0,  0, 0,   0, S_RUN,   4'b0000);
      add_vec(1, 1, R,  R,  0, 0, 0, 0, 0,  1, 0,  0, 0,   2, S_RUN,   4'b1100);
      add_vec(1, 1, AI, R,  3, 12,0, 1, 12, 0, 0,  0, 0,   4, S_RUN,   4'b1010);
      add_vec(1, 1, AI, R,  3, 12,0, 1, 12, 1, 12, 0, 0,   4, S_SPLIT, 4'b0010);
      add_vec(1, 1, AI, R,  3, 12,0, 1, 12, 0, 0,  0, 0,   4, S_SPLIT, 4'b0100);
      add_vec(1, 1, AI, AI, 3, 12,0, 3, 12, 0, 0,  0, 0,   6, S_RUN,   4'b1100);
      add_vec(1, 1, SW, R,  1, 2, 0, 2, 6,  0, 0,  0, 0,   8, S_RUN,   4'b1100);
      add_vec(1, 1, SW, R,  1, 2, 0, 3, 4,  1, 2,  0, 0,  10, S_RUN,   4'b0010);
      add_vec(1, 1, SW, R,  1, 2, 0, 3, 4,  0, 0,  0, 0,  10, S_STALL, 4'b0010);
      add_vec(1, 1, R,  R,  1, 2, 7, 7, 5,  0, 0,  1, 14, 10, S_RUN,   4'b0001);
      add_vec(1, 0, R,  R,  0, 0, 0, 0, 0,  0, 0,  1, 5,  14, S_FLUSH, 4'b0001);
      add_vec(1, 0, R,  R,  0, 0, 0, 0, 0,  0, 0,  0, 0,   5, S_FLUSH, 4'b0000);
      add_vec(0, 0, R,  R,  0, 0, 0, 0, 0,  0, 0,  0, 0,   7, S_RUN,   4'b0000);

      v = vecs[0];
      drive(v);
      repeat (2) @(posedge reloj);

      for (int i = 0; i < vecs.size(); i++) begin
         row = i;
         @(negedge reloj);
         drive(vecs[i]);
         #1;
         check("pc", {12'd0, pc}, {12'd0, vecs[i].e_pc});
         check("pc_4", {12'd0, pc_4}, {12'd0, vecs[i].e_pc + 4'd1});
         check("pc_8", {12'd0, pc_8}, {12'd0, vecs[i].e_pc + 4'd2});
         check("state", {14'd0, state}, {14'd0, vecs[i].e_st});
         check("outs", {12'd0, issue1, issue2, ifid_hold, ifid_flush}, {12'd0, vecs[i].e_out});
         check_counters();
         @(posedge reloj);
         advance_model(vecs[i].rst_n, vecs[i].e_st, vecs[i].e_out[3], vecs[i].e_out[2]);
      end

      // reset while a split pair is half issued
      row = 100;
      @(negedge reloj);
      v = vecs[3];
      v.rst_n = 1'b1;
      drive(v);
      #1;
      check("split_entry_issue1", {15'd0, issue1}, 16'd1);
      @(posedge reloj);
      advance_model(1'b1, S_RUN, 1'b1, 1'b0);
      @(negedge reloj);
      resetIF = 1'b0;
      #1;
      check("mid_split_state", {14'd0, state}, {14'd0, S_SPLIT});
      check_counters();
      @(posedge reloj);
      advance_model(1'b0, S_SPLIT, 1'b0, 1'b0);
      @(negedge reloj);
      resetIF = 1'b1;
      pair_valid = 1'b0;
      #1;
      check("post_reset_pc", {12'd0, pc}, 16'd0);
      check("post_reset_state", {14'd0, state}, {14'd0, S_RUN});
      check("post_reset_issue2", {15'd0, issue2}, 16'd0);
      check_counters();
      @(posedge reloj);
      exp_pc = 4'd2;

      // continuous dual issue across the PC wrap
      v = vecs[1];
      for (int i = 0; i < 9; i++) begin
         row = 200 + i;
         @(negedge reloj);
         drive(v);
         #1;
         check("wrap_pc", {12'd0, pc}, {12'd0, exp_pc});
         check("wrap_issue", {14'd0, issue1, issue2}, 16'd3);
         @(posedge reloj);
         advance_model(1'b1, S_RUN, 1'b1, 1'b1);
         exp_pc = exp_pc + 4'd2;
      end
      @(negedge reloj);
      pair_valid = 1'b0;
      #1;
      check("wrap_final_pc", {12'd0, pc}, {12'd0, exp_pc});
      check_counters();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
